// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the load/store front-end.
// Holds the size and state encodings plus the byte-lane mask, store
// replication and load extraction rules, so that future cache or DMA
// ports apply exactly the same lane rules.
package mem_access_pkg;

  typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2} mem_size_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  // Raw 2-bit size, so that the unused encoding 3 is caught here as well.
  function automatic logic misaligned(logic [1:0] size, logic [1:0] lane);
    return (size == 2'd3) || (size == 2'd1 && lane[0]) || (size == 2'd2 && lane != 2'd0);
  endfunction

  function automatic logic [3:0] lane_mask(mem_size_t size, logic [1:0] lane);
    case (size)
      SIZE_B:  return 4'b0001 << lane;
      SIZE_H:  return 4'b0011 << lane;
      SIZE_W:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data into every lane; the mask picks the live one.
  function automatic logic [31:0] lane_data(mem_size_t size, logic [31:0] wdata);
    case (size)
      SIZE_B:  return {4{wdata[7:0]}};
      SIZE_H:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract(logic [31:0] rdata, logic [1:0] lane,
                                          mem_size_t size, logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_B:  return is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_H:  return is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational load extraction.
//   rdata       - registered read word from RAM
//   lane        - byte offset of the access within the word
//   size        - access size (B/H/W)
//   is_unsigned - zero-extend instead of sign-extend
//   result      - right-aligned, extended load result
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  assign result = extract(rdata, lane, size, is_unsigned);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end for a word-wide synchronous RAM
// with a byte write mask and a 1-cycle registered read.
//   clk, reset_i                      - clock, async active-high reset
//   req_valid_i/req_ready_o           - request handshake (ready only in IDLE)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i - request fields
//   mem_addr_o, mem_we_o, mem_wr_mask_o, mem_wdata_o, mem_rdata_i - RAM side
//   rsp_valid_o/rsp_ready_i           - response handshake
//   rsp_rdata_o, rsp_err_o            - load result, misalignment/illegal-size flag
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_WORDS_W = 10
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_wr_mask_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  state_t                 state;
  logic [MEM_WORDS_W-1:0] word_q;
  logic [1:0]             lane_q;
  mem_size_t              size_q;
  logic                   uns_q;
  logic                   we_q;
  logic                   resp_first;  // first RESP cycle of a load: RAM data is live
  logic [31:0]            rdata_q;
  logic [31:0]            align_result;

  logic req_err;
  assign req_err = misaligned(req_size_i, req_addr_i[1:0]);

  // Upper address bits wrap within the RAM and carry no information.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[ADDR_W-1:MEM_WORDS_W+2];

  assign mem_addr_o = {{(ADDR_W-MEM_WORDS_W){1'b0}}, word_q};

  load_align u_align (
    .rdata       (mem_rdata_i),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (align_result)
  );

  // The RAM word only arrives in the first RESP cycle, so that cycle is served
  // straight from the aligner and the register holds it for any stall after.
  assign rsp_rdata_o = resp_first ? align_result : rdata_q;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      word_q        <= '0;
      lane_q        <= '0;
      size_q        <= SIZE_B;
      uns_q         <= 1'b0;
      we_q          <= 1'b0;
      resp_first    <= 1'b0;
      rdata_q       <= '0;
      req_ready_o   <= 1'b1;
      mem_we_o      <= 1'b0;
      mem_wr_mask_o <= '0;
      mem_wdata_o   <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_err_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            word_q      <= req_addr_i[MEM_WORDS_W+1:2];
            lane_q      <= req_addr_i[1:0];
            size_q      <= mem_size_t'(req_size_i);
            uns_q       <= req_unsigned_i;
            we_q        <= req_we_i;
            rdata_q     <= '0;
            req_ready_o <= 1'b0;
            if (req_err) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end else begin
              state <= ACCESS;
              if (req_we_i) begin
                mem_we_o      <= 1'b1;
                mem_wr_mask_o <= lane_mask(mem_size_t'(req_size_i), req_addr_i[1:0]);
                mem_wdata_o   <= lane_data(mem_size_t'(req_size_i), req_wdata_i);
              end
            end
          end
        end
        ACCESS: begin
          mem_we_o      <= 1'b0;
          mem_wr_mask_o <= '0;
          mem_wdata_o   <= '0;
          rsp_valid_o   <= 1'b1;
          resp_first    <= ~we_q;
          state         <= RESP;
        end
        RESP: begin
          resp_first <= 1'b0;
          if (resp_first) rdata_q <= align_result;
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rdata_q     <= '0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_we_o;
  logic [3:0]  mem_wr_mask_o;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wr_mask_o(mem_wr_mask_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o)
  );

  // 1024x32 RAM, byte mask, registered read
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_we_o)
      for (int i = 0; i < 4; i++)
        if (mem_wr_mask_o[i]) ram[mem_addr_o[9:0]][8*i +: 8] <= mem_wdata_o[8*i +: 8];
    mem_rdata_i <= ram[mem_addr_o[9:0]];
  end

  // Monitors
  int          we_count = 0;
  logic [3:0]  last_mask = 4'h0;
  int          cyc = 0;
  int          acc_cyc[$];
  logic [31:0] rsp_log[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we_o) begin we_count <= we_count + 1; last_mask <= mem_wr_mask_o; end
    if (req_valid_i && req_ready_o) acc_cyc.push_back(cyc);
    if (rsp_valid_o && rsp_ready_i) rsp_log.push_back(rsp_rdata_o);
  end

  // Reference model: byte-addressed memory, RAM-sized wrap
  logic [7:0] rmem [0:4095];

  function automatic logic m_err(logic [1:0] sz, logic [31:0] a);
    int nb;
    if (sz == 2'd3) return 1'b1;
    nb = 1 << sz;
    return (a % nb) != 0;
  endfunction

  task automatic m_store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) rmem[(a + i) % 4096] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] m_load(logic [1:0] sz, logic un, logic [31:0] a);
    logic [31:0] v;
    int nb;
    nb = 1 << sz;
    v = 0;
    for (int i = 0; i < nb; i++) v = v | (32'(rmem[(a + i) % 4096]) << (8*i));
    if (!un && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 1);
    chk({tag, "_mem_we"}, 32'(mem_we_o), 0);
    chk({tag, "_mask"}, 32'(mem_wr_mask_o), 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err_o), 0);
  endtask

  // One request; entered and left at #1 after a rising edge.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        input logic tog, output logic [31:0] rd, output logic er,
                        output int lat, output int wes);
    int w0, n;
    logic acc;
    logic [31:0] saved;
    w0 = we_count;
    req_valid_i = 1; req_we_i = we; req_size_i = sz; req_unsigned_i = un;
    req_addr_i = a; req_wdata_i = wd;
    acc = 0; n = 0;
    while (!acc && n < 20) begin acc = req_ready_o; @(posedge clk); #1; n++; end
    chk("accept_timeout", 32'(acc), 1);
    req_valid_i = 0; req_we_i = $urandom; req_size_i = 2'($urandom);
    req_addr_i = $urandom; req_wdata_i = $urandom;
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("rsp_timeout", 32'(rsp_valid_o), 1);
    rd = rsp_rdata_o; er = rsp_err_o;
    saved = ram[mem_addr_o[9:0]];
    for (int h = 0; h < hold; h++) begin
      if (tog) ram[mem_addr_o[9:0]] = ram[mem_addr_o[9:0]] ^ 32'hFFFF_FFFF;
      chk("hold_req_ready", 32'(req_ready_o), 0);
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid_o), 1);
      chk("hold_rdata", rsp_rdata_o, rd);
      chk("hold_err", 32'(rsp_err_o), 32'(er));
    end
    if (tog) ram[mem_addr_o[9:0]] = saved;
    rsp_ready_i = 1;
    @(posedge clk); #1;
    rsp_ready_i = 0;
    wes = we_count - w0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a, wd, rd;
    logic        er;
    int          lat, wes;
    logic [3:0]  mask;
  } vec_t;

  vec_t tbl [20];

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er, exp_er, we, un;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int          lat, wes, w0;
    logic        acc;

    tbl[0]  = '{1, 2, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0, 2, 1, 4'hF};
    tbl[1]  = '{0, 2, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 2, 0, 4'h0};
    tbl[2]  = '{1, 0, 0, 32'h13,       32'h80,       32'h0,        0, 2, 1, 4'h8};
    tbl[3]  = '{0, 0, 0, 32'h13,       32'h0,        32'hFFFFFF80, 0, 2, 0, 4'h0};
    tbl[4]  = '{0, 0, 1, 32'h13,       32'h0,        32'h00000080, 0, 2, 0, 4'h0};
    tbl[5]  = '{0, 2, 0, 32'h10,       32'h0,        32'h80ADBEEF, 0, 2, 0, 4'h0};
    tbl[6]  = '{1, 1, 0, 32'h22,       32'h1234,     32'h0,        0, 2, 1, 4'hC};
    tbl[7]  = '{0, 1, 0, 32'h21,       32'h0,        32'h0,        1, 1, 0, 4'h0};
    tbl[8]  = '{0, 1, 1, 32'h22,       32'h0,        32'h00001234, 0, 2, 0, 4'h0};
    tbl[9]  = '{0, 2, 0, 32'h22,       32'h0,        32'h0,        1, 1, 0, 4'h0};
    tbl[10] = '{1, 3, 0, 32'h0,        32'hFFFFFFFF, 32'h0,        1, 1, 0, 4'h0};
    tbl[11] = '{1, 2, 0, 32'h10000040, 32'hCAFEF00D, 32'h0,        0, 2, 1, 4'hF};
    tbl[12] = '{0, 2, 0, 32'h40,       32'h0,        32'hCAFEF00D, 0, 2, 0, 4'h0};
    tbl[13] = '{0, 1, 0, 32'h12,       32'h0,        32'hFFFF80AD, 0, 2, 0, 4'h0};
    tbl[14] = '{1, 0, 0, 32'h11,       32'hFFFFFF7F, 32'h0,        0, 2, 1, 4'h2};
    tbl[15] = '{0, 0, 0, 32'h11,       32'h0,        32'h0000007F, 0, 2, 0, 4'h0};
    tbl[16] = '{0, 1, 1, 32'h10,       32'h0,        32'h00007FEF, 0, 2, 0, 4'h0};
    tbl[17] = '{1, 1, 0, 32'h30,       32'hBEEF,     32'h0,        0, 2, 1, 4'h3};
    tbl[18] = '{0, 1, 0, 32'h30,       32'h0,        32'hFFFFBEEF, 0, 2, 0, 4'h0};
    tbl[19] = '{0, 0, 1, 32'h12,       32'h0,        32'h000000AD, 0, 2, 0, 4'h0};

    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    for (int i = 0; i < 4096; i++) rmem[i] = 8'h0;
    reset_i = 1; req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_unsigned_i = 0;
    req_addr_i = 0; req_wdata_i = 0; rsp_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    reset_i = 0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      do_req(tbl[i].we, tbl[i].sz, tbl[i].un, tbl[i].a, tbl[i].wd, i % 3, 1'b0, rd, er, lat, wes);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_wes", i), 32'(wes), 32'(tbl[i].wes));
      if (tbl[i].wes == 1) chk($sformatf("tbl%0d_mask", i), 32'(last_mask), 32'(tbl[i].mask));
      if (tbl[i].we && !m_err(tbl[i].sz, tbl[i].a)) m_store(tbl[i].sz, tbl[i].a, tbl[i].wd);
    end

    // Randomized against the model; addresses land in the low 64 bytes of a 4K page
    for (int i = 0; i < 150; i++) begin
      we = $urandom; sz = 2'($urandom_range(0, 3)); un = $urandom;
      a = $urandom & 32'hFFFF_F03F; wd = $urandom;
      exp_er = m_err(sz, a);
      exp_rd = (we || exp_er) ? 32'h0 : m_load(sz, un, a);
      do_req(we, sz, un, a, wd, $urandom_range(0, 3), 1'b0, rd, er, lat, wes);
      chk("rnd_rdata", rd, exp_rd);
      chk("rnd_err", 32'(er), 32'(exp_er));
      chk("rnd_lat", 32'(lat), exp_er ? 1 : 2);
      chk("rnd_wes", 32'(wes), (we && !exp_er) ? 1 : 0);
      if (we && !exp_er) m_store(sz, a, wd);
    end

    // Stalled response while RAM contents toggle underneath
    exp_rd = m_load(2'd2, 1'b0, 32'h10);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, 1'b1, rd, er, lat, wes);
    chk("stall_rdata", rd, exp_rd);
    chk("stall_err", 32'(er), 0);

    // Back-to-back: rsp_ready held high, valid held high
    acc_cyc.delete(); rsp_log.delete();
    w0 = we_count;
    rsp_ready_i = 1;
    for (int k = 0; k < 12; k++) begin
      req_valid_i = 1; req_we_i = (k < 6); req_size_i = 2'd2; req_unsigned_i = 0;
      req_addr_i = 32'h100 + 32'(4 * (k % 6)); req_wdata_i = 32'h1111_1111 * (k % 6 + 1);
      acc = 0;
      for (int n = 0; n < 20 && !acc; n++) begin acc = req_ready_o; @(posedge clk); #1; end
      chk("b2b_accept", 32'(acc), 1);
      if (k < 6) m_store(2'd2, req_addr_i, req_wdata_i);
    end
    req_valid_i = 0;
    repeat (4) @(posedge clk);
    #1; rsp_ready_i = 0;
    chk("b2b_writes", 32'(we_count - w0), 6);
    chk("b2b_accepts", 32'(acc_cyc.size()), 12);
    chk("b2b_rsps", 32'(rsp_log.size()), 12);
    for (int k = 1; k < 12 && k < acc_cyc.size(); k++)
      chk($sformatf("b2b_gap%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 3);
    for (int k = 0; k < 12 && k < rsp_log.size(); k++)
      chk($sformatf("b2b_rsp%0d", k), rsp_log[k],
          (k < 6) ? 32'h0 : m_load(2'd2, 1'b0, 32'h100 + 32'(4 * (k - 6))));

    // Reset in ACCESS of a store: the write must be dropped
    w0 = we_count;
    req_valid_i = 1; req_we_i = 1; req_size_i = 2'd2; req_addr_i = 32'h200; req_wdata_i = 32'h5555_5555;
    @(posedge clk); #1;
    req_valid_i = 0;
    chk("rstacc_we_pre", 32'(mem_we_o), 1);
    reset_i = 1; #1;
    chk_reset("rstacc");
    @(posedge clk); #1;
    reset_i = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("rstacc_no_rsp", 32'(rsp_valid_o), 0);
    end
    chk("rstacc_no_write", 32'(we_count - w0), 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0, 1'b0, rd, er, lat, wes);
    chk("rstacc_lw", rd, m_load(2'd2, 1'b0, 32'h200));

    // Reset in RESP of a load
    req_valid_i = 1; req_we_i = 0; req_size_i = 2'd2; req_addr_i = 32'h10;
    @(posedge clk); #1;
    req_valid_i = 0;
    @(posedge clk); #1;
    chk("rstrsp_valid_pre", 32'(rsp_valid_o), 1);
    reset_i = 1; #1;
    chk_reset("rstrsp");
    @(posedge clk); #1;
    reset_i = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("rstrsp_no_rsp", 32'(rsp_valid_o), 0);
    end
    do_req(1'b1, 2'd2, 1'b0, 32'h204, 32'h0BAD_F00D, 0, 1'b0, rd, er, lat, wes);
    chk("post_sw_wes", 32'(wes), 1);
    m_store(2'd2, 32'h204, 32'h0BAD_F00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 1, 1'b0, rd, er, lat, wes);
    chk("post_lw", rd, 32'h0BAD_F00D);
    chk("post_lw_lat", 32'(lat), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
